regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the scoreboarded multi-port register file.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 16;
    localparam int DEF_NRD    = 3;
    localparam int DEF_NWR    = 2;
    localparam int DEF_AW     = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]     addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve sets, write clears, flush clears all; NRD lookups.
module regfile_scoreboard #(
    parameter int NREGS    = 16,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_ok,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Ordering gives reserve priority over a same-cycle write, flush over both.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_ok[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        if (flush) busy_d = '0;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
    end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = DEF_NRD,
    parameter int NWR      = DEF_NWR,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic                  wr_collision
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NWR-1:0]    wr_ok;
    logic              coll_d;

    // Writes aimed at a hardwired-zero register are dropped before anything sees them.
    for (genvar j = 0; j < NWR; j++) begin : g_wr_ok
        assign wr_ok[j] = wr_en[j] &&
                          !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end

    always_comb begin
        coll_d = 1'b0;
        for (int unsigned j = 0; j < NWR; j++) begin
            for (int unsigned k = j + 1; k < NWR; k++) begin
                if (wr_ok[j] && wr_ok[k] && (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]))
                    coll_d = 1'b1;
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
            wr_collision <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_ok[j]) regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
            end
            wr_collision <= coll_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] val;
        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            val = regs[a];
            if ((BYPASS != 0) && !rst) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) val = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if ((ZERO_REG != 0) && (a == '0)) val = '0;
        end

        assign rd_data[i*DATA_W +: DATA_W] = val;
    end

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .NRD     (NRD),
        .NWR     (NWR),
        .ZERO_REG(ZERO_REG),
        .AW      (AW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .wr_ok   (wr_ok),
        .wr_addr (wr_addr),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .flush   (flush),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model feeds an expectation queue.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int BYPASS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        flush;
    logic        wr_collision;

    regfile_sb #(
        .DATA_W  (32),
        .NREGS   (16),
        .NRD     (3),
        .NWR     (2),
        .ZERO_REG(1),
        .BYPASS  (BYPASS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .wr_collision(wr_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    data_t m_reg  [16];
    logic  m_busy [16];
    logic  m_coll;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic data_t exp_read(input addr_t a);
        data_t v;
        if (rst || a == 4'd0) return '0;
        v = m_reg[a];
        if (BYPASS != 0) begin
            if (wr_en[0] && wr_addr[3:0] == a) v = wr_data[31:0];
            if (wr_en[1] && wr_addr[7:4] == a) v = wr_data[63:32];
        end
        return v;
    endfunction

    task automatic expect_outputs();
        addr_t a;
        for (int i = 0; i < 3; i++) begin
            a = rd_addr[i*4 +: 4];
            exp_q.push_back('{$sformatf("rd_data%0d@r%0d", i, a), i, exp_read(a)});
            exp_q.push_back('{$sformatf("rd_busy%0d@r%0d", i, a), 3 + i, {31'd0, m_busy[a]}});
        end
        exp_q.push_back('{"wr_collision", 6, {31'd0, m_coll}});
    endtask

    task automatic compare_outputs();
        exp_t        e;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0, 1, 2: got = rd_data[e.sel*32 +: 32];
                3, 4, 5: got = {31'd0, rd_busy[e.sel-3]};
                default: got = {31'd0, wr_collision};
            endcase
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_coll = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] hit;
        addr_t a0, a1;
        if (rst) begin
            model_clear();
            return;
        end
        a0 = wr_addr[3:0];
        a1 = wr_addr[7:4];
        hit = '0;
        m_coll = wr_en[0] && wr_en[1] && (a0 == a1) && (a0 != 4'd0);
        if (wr_en[0] && a0 != 4'd0) begin m_reg[a0] = wr_data[31:0];  hit[a0] = 1'b1; end
        if (wr_en[1] && a1 != 4'd0) begin m_reg[a1] = wr_data[63:32]; hit[a1] = 1'b1; end
        for (int r = 1; r < 16; r++) begin
            if (flush)                           m_busy[r] = 1'b0;
            else if (rsv_en && rsv_addr == r[3:0]) m_busy[r] = 1'b1;
            else if (hit[r])                     m_busy[r] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {a2[3:0], a1[3:0], a0[3:0]};
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*4 +: 4] = a[3:0];
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rsv(input int a);
        rsv_en = 1'b1;
        rsv_addr = a[3:0];
    endtask

    // Inputs are stable from the falling edge; sample, then clock the model.
    task automatic step();
        #2;
        expect_outputs();
        compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        model_clear();
        idle();
        set_rd(0, 1, 2);
        @(negedge clk);
        set_wr(0, 1, 32'h5);
        set_rsv(1);
        step();
        step();
        rst = 1'b0;
        idle();

        for (int a = 0; a < 16; a++) begin
            set_rd(a, (a + 5) % 16, (a + 11) % 16);
            step();
        end

        set_rd(5, 0, 1);
        set_wr(0, 5, 32'hDEADBEEF);
        step();
        idle();
        step();

        set_rd(7, 0, 5);
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        step();
        idle();
        step();
        step();
        set_wr(0, 0, 32'hAA);
        set_wr(1, 0, 32'hBB);
        set_rd(0, 7, 7);
        step();
        idle();
        step();

        set_rd(3, 3, 3);
        set_rsv(3);
        step();
        idle();
        step();
        set_wr(1, 3, 32'h33);
        step();
        idle();
        step();
        set_wr(0, 3, 32'h44);
        set_rsv(3);
        step();
        idle();
        step();
        set_rsv(3);
        step();
        idle();

        set_wr(0, 2, 32'h200);
        set_wr(1, 4, 32'h400);
        step();
        idle();
        set_wr(0, 6, 32'h600);
        step();
        idle();
        set_rsv(2); step();
        set_rsv(4); step();
        set_rsv(6); step();
        set_rd(2, 4, 6);
        set_rsv(9);
        flush = 1'b1;
        step();
        idle();
        step();
        set_rd(9, 3, 7);
        step();

        for (int n = 0; n < 60; n++) begin
            idle();
            set_rd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) set_wr(0, $urandom_range(0, 15), $urandom);
            if ($urandom_range(0, 1) == 1) set_wr(1, $urandom_range(0, 15), $urandom);
            if ($urandom_range(0, 2) == 0) set_rsv($urandom_range(0, 15));
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        idle();
        set_wr(0, 5, 32'h1234);
        step();
        idle();
        set_rsv(5);
        step();
        idle();
        set_rd(5, 5, 0);
        step();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        expect_outputs();
        compare_outputs();
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
